muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the dynamic-pipeline MIPS core. It sits beside the combinational ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU plus MTHI/MTLO through a start/busy/done handshake. It runs shift-add multiplication or restoring division at one bit per cycle, and it supports pipeline flush that aborts an in-flight operation.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_signfix.sv | 32 +++
 rtl/muldiv_unit.sv | 125 ++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and FIX-stage control flags for the multi-cycle mul/div unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   typedef struct packed {
      logic is_div;
      logic neg_res;
      logic neg_rem;
      logic div_zero;
   } fix_ctrl_t;

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Turns the unsigned magnitude result into the final HI/LO values (sign fix-up, divide-by-zero override).
module muldiv_signfix
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  fix_ctrl_t          ctrl,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   rem,
   input  logic [WIDTH-1:0]   a_raw,
   output logic [WIDTH-1:0]   hi_c,
   output logic [WIDTH-1:0]   lo_c
);

   logic [2*WIDTH-1:0] prod;

   always_comb begin
      prod = ctrl.neg_res ? -acc : acc;
      hi_c = prod[2*WIDTH-1:WIDTH];
      lo_c = prod[WIDTH-1:0];
      if (ctrl.is_div) begin
         if (ctrl.div_zero) begin
            hi_c = a_raw;
            lo_c = '1;
         end else begin
            lo_c = ctrl.neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_c = ctrl.neg_rem ? -rem : rem;
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers: shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [1:0]         state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_raw;
   fix_ctrl_t          ctrl;

   logic               sgn, accept, last;
   logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;
   logic [WIDTH:0]     msum, shifted, diff;

   // Operand magnitudes and one iteration of multiply/divide.
   always_comb begin
      sgn     = op_is_signed(op);
      a_mag   = (sgn && a[WIDTH-1]) ? -a : a;
      b_mag   = (sgn && b[WIDTH-1]) ? -b : b;
      accept  = start && !flush && (state == ST_IDLE) && !op[2];
      last    = (cnt == CW'(WIDTH - 1));
      msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted = {rem, acc[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept) state_nx = ST_CALC;
         ST_CALC: begin
            if (flush)     state_nx = ST_IDLE;
            else if (last) state_nx = ST_FIX;
         end
         ST_FIX:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
      .ctrl  (ctrl),
      .acc   (acc),
      .rem   (rem),
      .a_raw (a_raw),
      .hi_c  (fix_hi),
      .lo_c  (fix_lo)
   );

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         acc   <= '0;
         rem   <= '0;
         opnd  <= '0;
         a_raw <= '0;
         ctrl  <= '0;
      end else begin
         busy <= (state_nx != ST_IDLE);
         done <= (state == ST_FIX) && !flush;
         if ((state == ST_IDLE) && start && !flush) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
         end
         if (accept) begin
            cnt           <= '0;
            a_raw         <= a;
            opnd          <= op[1] ? b_mag : a_mag;
            acc           <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            rem           <= '0;
            ctrl.is_div   <= op[1];
            ctrl.neg_res  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            ctrl.neg_rem  <= sgn && a[WIDTH-1];
            ctrl.div_zero <= op[1] && (b == '0);
         end else if (state == ST_CALC) begin
            cnt <= cnt + CW'(1);
            if (ctrl.is_div) begin
               // diff MSB clear means the trial subtraction did not go negative
               if (!diff[WIDTH]) begin
                  rem            <= diff[WIDTH-1:0];
                  acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
               end else begin
                  rem            <= shifted[WIDTH-1:0];
                  acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc <= {msum, acc[WIDTH-1:1]};
            end
         end else if ((state == ST_FIX) && !flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops against a reference model, flush/reset corners.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst, start, flush;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] m_hi, m_lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model computed directly from the arithmetic definitions.
   task automatic ref_calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] rh, output logic [W-1:0] rl);
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      rh = m_hi;
      rl = m_lo;
      case (o)
         OP_MULT:  begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
         OP_MULTU: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
         OP_DIV: begin
            if (y == 0) begin rh = x; rl = '1; end
            else begin
               q = sx / sy; r = sx % sy;
               p = 64'(q); rl = p[31:0];
               p = 64'(r); rh = p[31:0];
            end
         end
         OP_DIVU: begin
            if (y == 0) begin rh = x; rl = '1; end
            else begin rl = x / y; rh = x % y; end
         end
         default: ;
      endcase
   endtask

   // Called at the negedge of cycle 0; returns at the negedge of cycle W+2.
   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
      int bad = 0;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= int'(W) + 1; c++) begin
         @(negedge clk);
         if (busy !== 1'b1 || done !== 1'b0) bad++;
      end
      @(negedge clk);
      check({name, " busy_window_bad_cycles"}, 64'(bad), 64'd0);
      check({name, " done"}, 64'(done), 64'd1);
      check({name, " busy_at_done"}, 64'(busy), 64'd0);
      check({name, " hi"}, 64'(hi), 64'(eh));
      check({name, " lo"}, 64'(lo), 64'(el));
      m_hi = eh;
      m_lo = el;
   endtask

   // MTHI/MTLO: called at negedge of cycle 0, returns at negedge of cycle 1.
   task automatic run_mt(input logic [2:0] o, input logic [W-1:0] x);
      start = 1'b1; op = o; a = x; b = $urandom;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (o == OP_MTHI) m_hi = x; else m_lo = x;
      check("mt busy", 64'(busy), 64'd0);
      check("mt done", 64'(done), 64'd0);
      check("mt hi", 64'(hi), 64'(m_hi));
      check("mt lo", 64'(lo), 64'(m_lo));
   endtask

   vec_t vecs[9];

   initial begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb, eh, el;
      int           bad;

      vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4] = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
      vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[6] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[8] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);

      // Directed table, issued back-to-back in the done cycle.
      for (int i = 0; i < 9; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

      // MTHI then MTLO in consecutive cycles.
      start = 1'b1; op = OP_MTHI; a = 32'hA5A5A5A5;
      @(negedge clk);
      check("mthi hi cycle1", 64'(hi), 64'hA5A5A5A5);
      check("mthi busy", 64'(busy), 64'd0);
      op = OP_MTLO; a = 32'h5A5A5A5A;
      @(negedge clk);
      start = 1'b0;
      check("mtlo lo cycle2", 64'(lo), 64'h5A5A5A5A);
      check("mtlo hi kept", 64'(hi), 64'hA5A5A5A5);
      check("mtlo busy", 64'(busy), 64'd0);
      m_hi = 32'hA5A5A5A5; m_lo = 32'h5A5A5A5A;

      // Flush in cycle 10 with an ignored MTHI in cycle 5.
      start = 1'b1; op = OP_MULT; a = 32'h00000123; b = 32'h00000456;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 5) begin start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF; end
         if (c == 6) start = 1'b0;
         if (c == 10) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      check("flush busy cycle11", 64'(busy), 64'd0);
      check("flush hi kept", 64'(hi), 64'(m_hi));
      check("flush lo kept", 64'(lo), 64'(m_lo));
      bad = 0;
      for (int c = 0; c < int'(W) + 4; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("flush no done", 64'(bad), 64'd0);

      // Flush in IDLE discards a concurrent MTHI.
      start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'h0BADF00D;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("idle flush mthi", 64'(hi), 64'(m_hi));

      // Flush in the FIX cycle.
      start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= int'(W) + 1; c++) begin
         @(negedge clk);
         if (c == int'(W) + 1) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      check("fix flush done", 64'(done), 64'd0);
      check("fix flush busy", 64'(busy), 64'd0);
      check("fix flush lo", 64'(lo), 64'(m_lo));
      @(negedge clk);
      check("fix flush done later", 64'(done), 64'd0);

      // Randomized ops against the model.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 9) < 8) begin
            ro = 3'($urandom_range(0, 3));
            ref_calc(ro, ra, rb, eh, el);
            run_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, eh, el);
         end else begin
            run_mt(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, ra);
         end
      end

      // Synchronous reset mid-CALC.
      start = 1'b1; op = OP_MULTU; a = 32'h12345678; b = 32'h9ABCDEF0;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset hi", 64'(hi), 64'd0);
      check("midreset lo", 64'(lo), 64'd0);
      check("midreset busy", 64'(busy), 64'd0);
      check("midreset done", 64'(done), 64'd0);
      m_hi = '0; m_lo = '0;
      run_op("post_reset", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
